serial_shift_right: RTL and testbench

Multi-cycle right-shift unit for the pipelined RISC-V datapath. It executes SRL/SRA/SRLI/SRAI one bit position per clock, with valid/ready handshakes on both sides, and is the counterpart to the fixed left-shift logic already in the datapath. It sits beside the ALU in EX. The pipeline stalls on `in_ready`/`out_valid`, and the unit aborts on a pipeline flush.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/serial_shift_right_if.sv | 28 ++
 rtl/shift_right_step.sv | 17 +
 rtl/serial_shift_right.sv | 109 ++++++++++
 tb/tb_serial_shift_right.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial right-shift unit: FSM states, default
// sizing and the SRL/SRA select encoding also used by the ALU decode.
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Funct7[5] of SRL/SRA maps straight onto this bit.
  typedef enum logic {
    SHIFT_SRL = 1'b0,
    SHIFT_SRA = 1'b1
  } shift_kind_e;

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_shift_right_if.sv
// Request/response handshake bundle between the EX stage and the shift unit.
interface serial_shift_right_if
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = shamt_width(WIDTH)
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_arith;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_arith, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_arith, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_right_step.sv
// One-position right shift of a word; arith selects sign fill over zero fill.
module shift_right_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             arith,
  output logic [WIDTH-1:0] dout
);

  logic fill;

  always_comb begin
    fill = arith & din[WIDTH-1];
    dout = {fill, din[WIDTH-1:1]};
  end

endmodule

// File: rtl/serial_shift_right.sv
// Multi-cycle SRL/SRA unit: shifts one bit per clock, handshakes on both sides,
// abortable by a pipeline flush.
module serial_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = shamt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic                 busy,
  serial_shift_right_if.slave  bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d;
  logic [WIDTH-1:0]   step_data;

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .din   (data_q),
    .arith (arith_q == logic'(SHIFT_SRA)),
    .dout  (step_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
    end
  end

  // Flush wins over everything, including a DONE-state out_ready.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_d = (bus.in_shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q <= SHAMT_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A flushed operation leaves data/count untouched; only the state resets.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_d  = bus.in_data;
            cnt_d   = bus.in_shamt;
            arith_d = bus.in_arith;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            data_d = step_data;
            cnt_d  = cnt_q - SHAMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = data_q;
    busy          = (state_q != IDLE);
  end

  a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !bus.out_ready && !flush) |=> (state_q == DONE && $stable(data_q)));

  a_shift_cnt_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SHIFT) |-> (cnt_q != '0));

endmodule

// File: tb/tb_serial_shift_right.sv
// Bench for serial_shift_right: directed vector table, corner-case sequences
// and randomized operations against a shift model.
module tb_serial_shift_right;

  localparam int W  = 32;
  localparam int SW = 5;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  int tests  = 0;
  int failed = 0;

  serial_shift_right_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  serial_shift_right #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] shamt;
    logic          arith;
    int            stall;
    bit            keep;
    logic [W-1:0]  expect_q;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] s,
                                         input logic a);
    logic signed [W-1:0] sd;
    sd = d;
    if (a) return W'(sd >>> s);
    return d >> s;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation from a negedge with the unit idle and follow it to completion.
  task automatic do_op(input logic [W-1:0] d, input logic [SW-1:0] s, input logic a,
                       input int stall, input bit keep, input logic [W-1:0] exp);
    int n;
    check("pre_in_ready", W'(bus.in_ready), W'(1));
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_shamt  = s;
    bus.in_arith  = a;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_shamt = SW'($urandom);
    bus.in_arith = 1'($urandom);
    check("busy_after_accept", W'(busy), W'(1));
    check("in_ready_after_accept", W'(bus.in_ready), W'(0));
    n = 0;
    while (!bus.out_valid && n < 40) begin
      if (keep) check("in_ready_held_valid", W'(bus.in_ready), W'(0));
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("latency", W'(n), W'(s));
    check("out_data", bus.out_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", W'(bus.out_valid), W'(1));
      check("stall_out_data", bus.out_data, exp);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("idle_after_done", W'({busy, bus.in_ready, bus.out_valid}), W'(3'b010));
  endtask

  initial begin
    int seen_valid;
    logic [W-1:0] rd;
    logic [SW-1:0] rs;
    logic ra;

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_arith  = 1'b0;
    bus.out_ready = 1'b1;

    vecs.push_back('{32'h8000_0000, 5'd4,  1'b0, 0, 1'b0, 32'h0800_0000});
    vecs.push_back('{32'h8000_0000, 5'd4,  1'b1, 0, 1'b1, 32'hF800_0000});
    vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 0, 1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{32'h7FFF_FFFF, 5'd31, 1'b1, 0, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h1234_5678, 5'd0,  1'b0, 0, 1'b0, 32'h1234_5678});
    vecs.push_back('{32'hF000_0000, 5'd3,  1'b0, 3, 1'b1, 32'h1E00_0000});
    vecs.push_back('{32'hFFFF_FFFF, 5'd31, 1'b0, 0, 1'b0, 32'h0000_0001});
    vecs.push_back('{32'hA5A5_A5A5, 5'd1,  1'b1, 1, 1'b0, 32'hD2D2_D2D2});

    #12;
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_out_data", bus.out_data, '0);
    check("reset_busy", W'(busy), W'(0));
    check("reset_in_ready", W'(bus.in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].stall, vecs[i].keep,
            vecs[i].expect_q);

    // Flush in the second SHIFT cycle with a competing request.
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF; bus.in_shamt = 5'd10; bus.in_arith = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h0000_00FF; bus.in_shamt = 5'd2;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_idle", W'({busy, bus.in_ready, bus.out_valid}), W'(3'b010));
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen_valid++;
    end
    check("flush_no_pulse", W'(seen_valid), W'(0));
    do_op(32'h8000_00F0, 5'd4, 1'b1, 0, 1'b0, 32'hF800_000F);

    // Asynchronous reset in the middle of a long shift.
    bus.in_valid = 1'b1; bus.in_data = 32'hCAFE_F00D; bus.in_shamt = 5'd20; bus.in_arith = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", W'(bus.out_valid), W'(0));
    check("rst_mid_busy", W'(busy), W'(0));
    check("rst_mid_out_data", bus.out_data, '0);
    check("rst_mid_in_ready", W'(bus.in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h0000_0002, 5'd1, 1'b0, 0, 1'b0, 32'h0000_0001);

    for (int i = 0; i < 24; i++) begin
      rd = $urandom;
      rs = SW'($urandom);
      ra = 1'($urandom);
      do_op(rd, rs, ra, int'($urandom_range(0, 2)), 1'($urandom), model(rd, rs, ra));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
